// File: rtl/serial_add_vr_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_add_vr_pkg;

    // Same operand width the 4-bit ripple adder is exercised with.
    localparam int ADD_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/fa_vr.sv
// Single-bit full-adder cell.
module fa_vr (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_vr.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit
// operands LSB-first, one bit per clock, with a one-cycle done pulse.
module serial_add_vr
    import serial_add_vr_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_a, reg_b, sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             load, shift;
    logic             fa_sum, fa_cout;

    fa_vr u_fa (
        .sum   (fa_sum),
        .c_out (fa_cout),
        .a     (reg_a[0]),
        .b     (reg_b[0]),
        .c_in  (carry_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                // A start in the done cycle is taken directly for back-to-back adds.
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a   <= '0;
            reg_b   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            reg_a   <= a;
            reg_b   <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (shift) begin
            reg_a   <= reg_a >> 1;
            reg_b   <= reg_b >> 1;
            // Shift-based insert keeps WIDTH=1 legal (no [0:1] slice).
            sum_q   <= (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign c_out = carry_q;

endmodule
